// File: rtl/uart_transmitter_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_transmitter_pkg
// Description : UART state encodings and default frame-format constants,
//               shared between the transmitter and the receiver.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package uart_transmitter_pkg;

    localparam int c_BYTE_W          = 8;
    localparam int c_DEF_DATA_BITS   = 8;
    localparam int c_DEF_PARITY_EN   = 0;
    localparam int c_DEF_PARITY_ODD  = 0;
    localparam int c_DEF_STOP_BITS   = 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_transmitter_if.sv
//------------------------------------------------------------------------------
// Module      : uart_transmitter_if
// Description : Byte write handshake and serial line of the UART transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface uart_transmitter_if;
    import uart_transmitter_pkg::*;

    logic                wr_en;
    logic [c_BYTE_W-1:0] din;
    logic                tx_ready;
    logic                busy;
    logic                tx;

    modport master (
        output wr_en,
        output din,
        input  tx_ready,
        input  busy,
        input  tx
    );

    modport slave (
        input  wr_en,
        input  din,
        output tx_ready,
        output busy,
        output tx
    );

endinterface

`default_nettype wire

// File: rtl/uart_transmitter.sv
//------------------------------------------------------------------------------
// Module      : uart_transmitter
// Description : LSB-first UART serializer with a one-entry holding register,
//               optional parity and 1 or 2 stop bits, paced by a 1x baud tick.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int DATA_BITS  = c_DEF_DATA_BITS,
    parameter int PARITY_EN  = c_DEF_PARITY_EN,
    parameter int PARITY_ODD = c_DEF_PARITY_ODD,
    parameter int STOP_BITS  = c_DEF_STOP_BITS
)(
    input  wire logic         clk_50mhz,
    input  wire logic         rst_n,
    input  wire logic         clken,
    uart_transmitter_if.slave bus
);

    localparam int                  c_MASK_INT  = (1 << DATA_BITS) - 1;
    localparam logic [c_BYTE_W-1:0] c_DATA_MASK = c_MASK_INT[c_BYTE_W-1:0];
    localparam logic [2:0]          c_LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic                c_LAST_STOP = 1'(STOP_BITS - 1);
    localparam logic                c_PAR_ODD   = (PARITY_ODD != 0);

    uart_state_t         r_state;
    logic [c_BYTE_W-1:0] r_hold;
    logic [c_BYTE_W-1:0] r_shift;
    logic                r_hold_par;
    logic                r_shift_par;
    logic                r_hold_full;
    logic                r_tx_ready;
    logic [2:0]          r_bit_cnt;
    logic                r_stop_cnt;
    logic                r_tx;
    logic                r_busy;

    logic                w_accept;
    logic                w_consume;
    logic                w_din_par;

    // The hold register is emptied exactly on the ticks where the FSM loads it.
    always_comb begin
        w_accept  = bus.wr_en && r_tx_ready;
        w_consume = clken && r_hold_full &&
                    ((r_state == IDLE) ||
                     ((r_state == STOP) && (r_stop_cnt == c_LAST_STOP)));
        w_din_par = (^(bus.din & c_DATA_MASK)) ^ c_PAR_ODD;
    end

    always_ff @(posedge clk_50mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_hold      <= '0;
            r_shift     <= '0;
            r_hold_par  <= 1'b0;
            r_shift_par <= 1'b0;
            r_hold_full <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_bit_cnt   <= 3'd0;
            r_stop_cnt  <= 1'b0;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= bus.din;
                r_hold_par  <= w_din_par;
                r_hold_full <= 1'b1;
                r_tx_ready  <= 1'b0;
            end else if (w_consume) begin
                r_hold_full <= 1'b0;
                r_tx_ready  <= 1'b1;
            end

            if (clken) begin
                case (r_state)
                    IDLE: begin
                        if (r_hold_full) begin
                            r_tx        <= 1'b0;
                            r_shift     <= r_hold;
                            r_shift_par <= r_hold_par;
                            r_busy      <= 1'b1;
                            r_state     <= START;
                        end
                    end
                    START: begin
                        r_tx      <= r_shift[0];
                        r_shift   <= {1'b0, r_shift[c_BYTE_W-1:1]};
                        r_bit_cnt <= 3'd0;
                        r_state   <= DATA;
                    end
                    DATA: begin
                        if (r_bit_cnt != c_LAST_BIT) begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[c_BYTE_W-1:1]};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end else if (PARITY_EN != 0) begin
                            r_tx    <= r_shift_par;
                            r_state <= PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_stop_cnt <= 1'b0;
                            r_state    <= STOP;
                        end
                    end
                    PARITY: begin
                        r_tx       <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= STOP;
                    end
                    STOP: begin
                        if (r_stop_cnt != c_LAST_STOP) begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end else if (r_hold_full) begin
                            // Queued byte follows with no idle bit between frames.
                            r_tx        <= 1'b0;
                            r_shift     <= r_hold;
                            r_shift_par <= r_hold_par;
                            r_state     <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_tx    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.tx       = r_tx;
    assign bus.busy     = r_busy;
    assign bus.tx_ready = r_tx_ready;

endmodule

`default_nettype wire

// File: tb/tb_uart_transmitter.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_transmitter
// Description : Directed self-checking bench for uart_transmitter (8N1, 8E2, 8O2).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_uart_transmitter;

    logic clk_50mhz = 1'b0;
    logic rst_n     = 1'b0;
    logic clken     = 1'b0;
    int   div       = 16;
    int   cnt       = 0;

    int   checks    = 0;
    int   errors    = 0;

    logic cap_tx   [0:63];
    logic cap_busy [0:63];
    int   cap_n     = 0;

    uart_transmitter_if if0 ();
    uart_transmitter_if if1 ();
    uart_transmitter_if if2 ();

    uart_transmitter #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_8n1 (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .clken     (clken),
        .bus       (if0.slave)
    );

    uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_8e2 (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .clken     (clken),
        .bus       (if1.slave)
    );

    uart_transmitter #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut_8o2 (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .clken     (clken),
        .bus       (if2.slave)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Baud tick generator, updated on the falling edge so the DUT sees a stable level.
    always @(negedge clk_50mhz) begin
        if (cnt >= div - 1) begin
            cnt   = 0;
            clken = 1'b1;
        end else begin
            cnt   = cnt + 1;
            clken = 1'b0;
        end
    end

    function automatic logic sel_tx(input int sel);
        case (sel)
            0:       return if0.tx;
            1:       return if1.tx;
            default: return if2.tx;
        endcase
    endfunction

    function automatic logic sel_busy(input int sel);
        case (sel)
            0:       return if0.busy;
            1:       return if1.busy;
            default: return if2.busy;
        endcase
    endfunction

    task automatic wait_tick();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 64; k++) begin
            @(posedge clk_50mhz);
            if (clken) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no clken, expected one within 64 clocks");
        end
        #1;
    endtask

    task automatic run_ticks(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            wait_tick();
            if (cap_n < 64) begin
                cap_tx[cap_n]   = sel_tx(sel);
                cap_busy[cap_n] = sel_busy(sel);
                cap_n++;
            end
        end
    endtask

    task automatic write_byte(input int sel, input logic [7:0] d);
        @(negedge clk_50mhz);
        case (sel)
            0:       begin if0.wr_en = 1'b1; if0.din = d; end
            1:       begin if1.wr_en = 1'b1; if1.din = d; end
            default: begin if2.wr_en = 1'b1; if2.din = d; end
        endcase
        @(negedge clk_50mhz);
        if0.wr_en = 1'b0;
        if1.wr_en = 1'b0;
        if2.wr_en = 1'b0;
    endtask

    task automatic test_reset();
        #35;
        checks++;
        if (if0.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", if0.tx); end
        checks++;
        if (if0.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", if0.busy); end
        checks++;
        if (if0.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b expected 1", if0.tx_ready); end
        checks++;
        if (if1.tx !== 1'b1) begin errors++; $display("FAIL reset_tx_8e2: got %b expected 1", if1.tx); end
        @(negedge clk_50mhz);
        rst_n = 1'b1;
        cap_n = 0;
        run_ticks(0, 2);
        checks++;
        if ({cap_tx[0], cap_tx[1], cap_busy[0], cap_busy[1]} !== 4'b1100) begin
            errors++;
            $display("FAIL idle_ticks: got tx/busy %b%b/%b%b expected 11/00",
                     cap_tx[0], cap_tx[1], cap_busy[0], cap_busy[1]);
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_tx;
        exp_tx = 10'b0_10100101_1;
        cap_n  = 0;
        write_byte(0, 8'hA5);
        checks++;
        if (if0.tx_ready !== 1'b0) begin errors++; $display("FAIL a5_hold_ready: got %b expected 0", if0.tx_ready); end
        run_ticks(0, 1);
        checks++;
        if (if0.tx_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_after_start: got %b expected 1", if0.tx_ready); end
        run_ticks(0, 10);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (cap_tx[i] !== exp_tx[9 - i] || cap_busy[i] !== 1'b1) begin
                errors++;
                $display("FAIL a5_tick%0d: got tx=%b busy=%b expected tx=%b busy=1",
                         i, cap_tx[i], cap_busy[i], exp_tx[9 - i]);
            end
        end
        checks++;
        if (cap_tx[10] !== 1'b1 || cap_busy[10] !== 1'b0) begin
            errors++;
            $display("FAIL a5_end: got tx=%b busy=%b expected tx=1 busy=0", cap_tx[10], cap_busy[10]);
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp_tx;
        int          bad;
        exp_tx = 20'b0_00000000_1_0_11111111_1;
        cap_n  = 0;
        bad    = 0;
        write_byte(0, 8'h00);
        run_ticks(0, 1);
        write_byte(0, 8'hFF);
        checks++;
        if (if0.tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready: got %b expected 0", if0.tx_ready); end
        run_ticks(0, 20);
        for (int i = 0; i < 20; i++) begin
            if (cap_tx[i] !== exp_tx[19 - i] || cap_busy[i] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL b2b_line: got %0d wrong ticks expected 0 (tick10 tx=%b tick11 tx=%b)",
                     bad, cap_tx[9], cap_tx[10]);
        end
        checks++;
        if (cap_busy[20] !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", cap_busy[20]); end
    endtask

    task automatic test_overrun();
        logic [23:0] exp_tx;
        int          bad;
        exp_tx = 24'b0_10001000_1_0_00111100_1_1111;
        cap_n  = 0;
        bad    = 0;
        write_byte(0, 8'h11);
        run_ticks(0, 1);
        write_byte(0, 8'h3C);
        checks++;
        if (if0.tx_ready !== 1'b0) begin errors++; $display("FAIL ovr_ready: got %b expected 0", if0.tx_ready); end
        write_byte(0, 8'hC3);
        run_ticks(0, 23);
        for (int i = 0; i < 24; i++) begin
            if (cap_tx[i] !== exp_tx[23 - i]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ovr_line: got %0d wrong ticks expected 0", bad); end
        checks++;
        if (cap_busy[19] !== 1'b1 || cap_busy[20] !== 1'b0 || cap_busy[23] !== 1'b0) begin
            errors++;
            $display("FAIL ovr_busy: got %b%b%b expected 100", cap_busy[19], cap_busy[20], cap_busy[23]);
        end
    endtask

    task automatic test_parity();
        logic [11:0] exp_even;
        logic [11:0] exp_odd;
        int          bad;
        exp_even = 12'b0_11100000_1_11;
        exp_odd  = 12'b0_11100000_0_11;
        cap_n = 0;
        bad   = 0;
        write_byte(1, 8'h07);
        run_ticks(1, 13);
        for (int i = 0; i < 12; i++) begin
            if (cap_tx[i] !== exp_even[11 - i]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL even_line: got %0d wrong ticks expected 0 (parity tx=%b)", bad, cap_tx[9]); end
        checks++;
        if (cap_busy[11] !== 1'b1 || cap_busy[12] !== 1'b0) begin
            errors++;
            $display("FAIL even_2stop_busy: got %b%b expected 10", cap_busy[11], cap_busy[12]);
        end
        cap_n = 0;
        bad   = 0;
        write_byte(2, 8'h07);
        run_ticks(2, 13);
        for (int i = 0; i < 12; i++) begin
            if (cap_tx[i] !== exp_odd[11 - i]) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL odd_line: got %0d wrong ticks expected 0 (parity tx=%b)", bad, cap_tx[9]); end
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        cap_n = 0;
        bad   = 0;
        write_byte(0, 8'h00);
        run_ticks(0, 1);
        write_byte(0, 8'h0F);
        run_ticks(0, 3);
        checks++;
        if (if0.tx !== 1'b0 || if0.busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got tx=%b busy=%b expected tx=0 busy=1", if0.tx, if0.busy);
        end
        @(negedge clk_50mhz);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (if0.tx !== 1'b1 || if0.busy !== 1'b0 || if0.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async: got tx=%b busy=%b ready=%b expected 1 0 1", if0.tx, if0.busy, if0.tx_ready);
        end
        repeat (3) @(negedge clk_50mhz);
        rst_n = 1'b1;
        cap_n = 0;
        run_ticks(0, 15);
        for (int i = 0; i < 15; i++) begin
            if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mid_residual: got %0d active ticks expected 0", bad); end
    endtask

    task automatic test_continuous_clken();
        @(negedge clk_50mhz);
        #1;
        div = 1;
        repeat (3) @(negedge clk_50mhz);
        write_byte(0, 8'h81);
        checks++;
        if (if0.tx !== 1'b1 || if0.busy !== 1'b0) begin
            errors++;
            $display("FAIL cont_write_cycle: got tx=%b busy=%b expected tx=1 busy=0", if0.tx, if0.busy);
        end
        wait_tick();
        checks++;
        if (if0.tx !== 1'b0) begin errors++; $display("FAIL cont_start: got %b expected 0", if0.tx); end
        repeat (10) wait_tick();
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [0:4];
        logic [7:0] rx;
        int         frames;
        bit         seen;
        bytes[0] = 8'h00; bytes[1] = 8'h55; bytes[2] = 8'hAA; bytes[3] = 8'hFF; bytes[4] = 8'h81;
        frames = 0;
        for (int b = 0; b < 5; b++) begin
            write_byte(0, bytes[b]);
            seen = 1'b0;
            for (int k = 0; k < 4 && !seen; k++) begin
                wait_tick();
                if (if0.tx === 1'b0) seen = 1'b1;
            end
            rx = 8'h00;
            for (int j = 0; j < 8; j++) begin
                wait_tick();
                rx = {if0.tx, rx[7:1]};
            end
            wait_tick();
            if (seen && if0.tx === 1'b1) frames++;
            checks++;
            if (rx !== bytes[b]) begin errors++; $display("FAIL loop_byte%0d: got %h expected %h", b, rx, bytes[b]); end
            wait_tick();
        end
        checks++;
        if (frames != 5) begin errors++; $display("FAIL loop_frames: got %0d expected 5", frames); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected end within 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        if0.wr_en = 1'b0; if0.din = 8'h00;
        if1.wr_en = 1'b0; if1.din = 8'h00;
        if2.wr_en = 1'b0; if2.din = 8'h00;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overrun();
        test_parity();
        test_reset_mid_frame();
        test_continuous_clken();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
